// File: rtl/CacheSystemTypes.sv
// Shared types and defaults for the cache flush manager and its per-target trackers.
// Phase encoding leaves values 4..7 unused; the manager recovers from those to FREE.
package CacheSystemTypes;

    localparam int DEFAULT_NUM_TARGETS    = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        FREE         = 3'd0,
        SEND_REQUEST = 3'd1,
        PROCESSING   = 3'd2,
        WAITING      = 3'd3
    } flushPhase_t;

    function automatic int watchdogWidth(input int timeoutCycles);
        return (timeoutCycles < 1) ? 1 : $clog2(timeoutCycles + 1);
    endfunction

endpackage

// File: rtl/cache_flush_target_tracker.sv
// Per-target mask/issued/done flags; the request is combinational from flags and ack.
// A target is never asked twice: issued blocks further requests until the next start.
module cache_flush_target_tracker (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic startMask,
    input  logic issuePhase,
    input  logic trackPhase,
    input  logic ack,
    input  logic doneIn,
    output logic req,
    output logic doneHit,
    output logic maskBit,
    output logic issued,
    output logic done
);

    assign req     = issuePhase & maskBit & ~issued & ack;
    // Only a done for a request already registered as issued counts.
    assign doneHit = trackPhase & maskBit & issued & doneIn;

    always_ff @(posedge clk) begin
        if (rst) begin
            maskBit <= 1'b0;
            issued  <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            maskBit <= startMask;
            issued  <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (req) begin
                issued <= 1'b1;
            end
            if (doneHit) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_cache_flush_manager.sv
// Fans one flush request out to NUM_TARGETS caches, collects completions, watchdog-guarded.
// Requests wait per target for its ack; the result is held in WAITING until flushReq releases it.
module multi_cache_flush_manager
    import CacheSystemTypes::*;
#(
    parameter int NUM_TARGETS    = DEFAULT_NUM_TARGETS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flushReq,
    input  logic [NUM_TARGETS-1:0] flushMask,
    output logic                   flushComplete,
    output logic                   flushTimeout,
    output logic                   busy,
    output logic [NUM_TARGETS-1:0] tgtFlushReq,
    input  logic [NUM_TARGETS-1:0] tgtFlushReqAck,
    input  logic [NUM_TARGETS-1:0] tgtFlushDone,
    output logic [NUM_TARGETS-1:0] tgtDoneStatus
);

    localparam int              WD_W     = watchdogWidth(TIMEOUT_CYCLES);
    localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    flushPhase_t            phase;
    logic [WD_W-1:0]        wdog;
    logic [WD_W-1:0]        wdogNext;
    logic                   timeoutFlag;

    logic [NUM_TARGETS-1:0] maskVec;
    logic [NUM_TARGETS-1:0] issuedVec;
    logic [NUM_TARGETS-1:0] doneVec;
    logic [NUM_TARGETS-1:0] reqVec;
    logic [NUM_TARGETS-1:0] doneHitVec;

    logic phaseValid;
    logic issuePhase;
    logic trackPhase;
    logic start;
    logic trackerClear;
    logic allIssued;
    logic allDone;
    logic timeoutHit;

    assign phaseValid   = phase inside {FREE, SEND_REQUEST, PROCESSING, WAITING};
    assign issuePhase   = (phase == SEND_REQUEST);
    assign trackPhase   = issuePhase | (phase == PROCESSING);
    assign start        = (phase == FREE) & flushReq;
    assign trackerClear = rst | ~phaseValid;

    // Requests and dones landing this cycle count toward the exit conditions.
    assign allIssued  = &(~maskVec | issuedVec | reqVec);
    assign allDone    = &(~maskVec | doneVec | doneHitVec);
    assign timeoutHit = WD_EN && (wdog == WD_LIMIT);
    assign wdogNext   = (WD_EN && (wdog != WD_LIMIT)) ? wdog + WD_W'(1) : wdog;

    for (genvar i = 0; i < NUM_TARGETS; i++) begin : gTarget
        cache_flush_target_tracker uTracker (
            .clk        (clk),
            .rst        (trackerClear),
            .start      (start),
            .startMask  (flushMask[i]),
            .issuePhase (issuePhase),
            .trackPhase (trackPhase),
            .ack        (tgtFlushReqAck[i]),
            .doneIn     (tgtFlushDone[i]),
            .req        (reqVec[i]),
            .doneHit    (doneHitVec[i]),
            .maskBit    (maskVec[i]),
            .issued     (issuedVec[i]),
            .done       (doneVec[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= FREE;
            wdog        <= '0;
            timeoutFlag <= 1'b0;
        end else begin
            case (phase)
                FREE: begin
                    if (flushReq) begin
                        wdog        <= '0;
                        timeoutFlag <= 1'b0;
                        phase       <= (flushMask != '0) ? SEND_REQUEST : WAITING;
                    end
                end
                SEND_REQUEST: begin
                    if (timeoutHit) begin
                        phase       <= WAITING;
                        timeoutFlag <= 1'b1;
                    end else begin
                        wdog <= wdogNext;
                        if (allIssued) begin
                            phase <= PROCESSING;
                        end
                    end
                end
                PROCESSING: begin
                    // Completion beats a watchdog expiry in the same cycle.
                    if (allDone) begin
                        phase       <= WAITING;
                        timeoutFlag <= 1'b0;
                    end else if (timeoutHit) begin
                        phase       <= WAITING;
                        timeoutFlag <= 1'b1;
                    end else begin
                        wdog <= wdogNext;
                    end
                end
                WAITING: begin
                    if (flushReq) begin
                        phase <= FREE;
                    end
                end
                default: begin
                    phase       <= FREE;
                    wdog        <= '0;
                    timeoutFlag <= 1'b0;
                end
            endcase
        end
    end

    assign flushComplete = (phase == WAITING);
    assign flushTimeout  = (phase == WAITING) & timeoutFlag;
    assign busy          = trackPhase;
    assign tgtFlushReq   = reqVec;
    assign tgtDoneStatus = phaseValid ? doneVec : '0;

endmodule

// File: tb/tb_multi_cache_flush_manager.sv
// Bench for multi_cache_flush_manager: directed scenarios plus random traffic vs a flush-level model.
module tb_multi_cache_flush_manager;

    localparam int NT = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flushReq;
    logic [NT-1:0] flushMask;
    logic [NT-1:0] tgtFlushReqAck;
    logic [NT-1:0] tgtFlushDone;
    logic          flushComplete;
    logic          flushTimeout;
    logic          busy;
    logic [NT-1:0] tgtFlushReq;
    logic [NT-1:0] tgtDoneStatus;

    int tests = 0;
    int fails = 0;

    multi_cache_flush_manager #(.NUM_TARGETS(NT), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .flushReq       (flushReq),
        .flushMask      (flushMask),
        .flushComplete  (flushComplete),
        .flushTimeout   (flushTimeout),
        .busy           (busy),
        .tgtFlushReq    (tgtFlushReq),
        .tgtFlushReqAck (tgtFlushReqAck),
        .tgtFlushDone   (tgtFlushDone),
        .tgtDoneStatus  (tgtDoneStatus)
    );

    always #5 clk = ~clk;

    wire [2*NT+2:0] obsVec = {flushComplete, flushTimeout, busy, tgtFlushReq, tgtDoneStatus};

    // Flush-level reference: a flush is running, still handing out requests, or finished.
    bit          mRunning  = 0;
    bit          mIssuing  = 0;
    bit          mFinished = 0;
    bit          mTimedOut = 0;
    bit [NT-1:0] mMask     = '0;
    bit [NT-1:0] mIssued   = '0;
    bit [NT-1:0] mDone     = '0;
    int          mBusy     = 0;

    function automatic logic [2*NT+2:0] predict();
        logic [NT-1:0] req;
        req = mIssuing ? (mMask & ~mIssued & tgtFlushReqAck) : '0;
        return {mFinished, mFinished & mTimedOut, mRunning, req, mDone};
    endfunction

    task automatic modelClock();
        bit [NT-1:0] req;
        bit [NT-1:0] hits;
        req  = mIssuing ? (mMask & ~mIssued & tgtFlushReqAck) : '0;
        hits = mRunning ? (tgtFlushDone & mMask & mIssued) : '0;
        if (rst) begin
            mRunning = 0; mIssuing = 0; mFinished = 0; mTimedOut = 0;
            mMask = '0; mIssued = '0; mDone = '0; mBusy = 0;
        end else if (mFinished) begin
            if (flushReq) mFinished = 0;
        end else if (!mRunning) begin
            if (flushReq) begin
                mMask = flushMask; mIssued = '0; mDone = '0; mTimedOut = 0; mBusy = 0;
                if (flushMask == '0) mFinished = 1;
                else begin mRunning = 1; mIssuing = 1; end
            end
        end else begin
            mBusy++;
            mDone   |= hits;
            mIssued |= req;
            if (mIssuing) begin
                if (mBusy == TO) begin
                    mRunning = 0; mIssuing = 0; mFinished = 1; mTimedOut = 1;
                end else if ((mIssued & mMask) == mMask) begin
                    mIssuing = 0;
                end
            end else if ((mDone & mMask) == mMask) begin
                mRunning = 0; mFinished = 1; mTimedOut = 0;
            end else if (mBusy == TO) begin
                mRunning = 0; mFinished = 1; mTimedOut = 1;
            end
        end
    endtask

    task automatic setIn(input logic r, input logic fr, input logic [NT-1:0] fm,
                         input logic [NT-1:0] ak, input logic [NT-1:0] dn);
        rst = r; flushReq = fr; flushMask = fm; tgtFlushReqAck = ak; tgtFlushDone = dn;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        modelClock();
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c <= 2; c++) begin
            setIn(c < 2, c < 2 ? 1'($urandom) : 1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
            if (c > 0) begin
                tests++;
                if (obsVec !== '0) begin
                    fails++; $display("FAIL reset c=%0d got=%b exp=0", c, obsVec);
                end
            end
            tick();
        end
    endtask

    task automatic test_basic();
        for (int c = 0; c <= 14; c++) begin
            setIn(1'b0, c == 0 || c == 12, 4'b0011, 4'b1111,
                  c == 5 ? 4'b0001 : (c == 9 ? 4'b0010 : 4'b0000));
            tests++;
            if (obsVec !== predict()) begin
                fails++; $display("FAIL basic c=%0d got=%b exp=%b", c, obsVec, predict());
            end
            if (c == 1) begin
                tests++;
                if (tgtFlushReq !== 4'b0011) begin
                    fails++; $display("FAIL basic_req c=1 got=%b exp=0011", tgtFlushReq);
                end
            end
            if (c == 2) begin
                tests++;
                if (tgtFlushReq !== 4'b0000) begin
                    fails++; $display("FAIL basic_norepeat got=%b exp=0000", tgtFlushReq);
                end
            end
            if (c == 9 || c == 10) begin
                tests++;
                if (flushComplete !== (c == 10)) begin
                    fails++; $display("FAIL basic_complete c=%0d got=%b", c, flushComplete);
                end
            end
            if (c == 13) begin
                tests++;
                if ({flushComplete, busy} !== 2'b00) begin
                    fails++; $display("FAIL basic_free got=%b exp=00", {flushComplete, busy});
                end
            end
            tick();
        end
    endtask

    task automatic test_staggered();
        logic [NT-1:0] ak;
        for (int c = 0; c <= 11; c++) begin
            ak = (c == 1) ? 4'b0001 : ((c == 4) ? 4'b1111 : 4'b1101);
            setIn(1'b0, c == 0 || c == 10, 4'b0011, ak, c == 7 ? 4'b0011 : 4'b0000);
            tests++;
            if (obsVec !== predict()) begin
                fails++; $display("FAIL staggered c=%0d got=%b exp=%b", c, obsVec, predict());
            end
            if (c >= 1 && c <= 5) begin
                tests++;
                if (tgtFlushReq !== ((c == 1) ? 4'b0001 : ((c == 4) ? 4'b0010 : 4'b0000))) begin
                    fails++; $display("FAIL staggered_req c=%0d got=%b", c, tgtFlushReq);
                end
            end
            if (c == 8) begin
                tests++;
                if (flushComplete !== 1'b1) begin
                    fails++; $display("FAIL staggered_complete got=%b exp=1", flushComplete);
                end
            end
            tick();
        end
    endtask

    task automatic test_ignored_done();
        logic [NT-1:0] dn;
        for (int c = 0; c <= 10; c++) begin
            case (c)
                0, 1, 5: dn = 4'b0001;
                3:       dn = 4'b1010;
                7:       dn = 4'b0100;
                default: dn = 4'b0000;
            endcase
            setIn(1'b0, c == 0 || c == 9, 4'b0101, 4'b1111, dn);
            tests++;
            if (obsVec !== predict()) begin
                fails++; $display("FAIL ignored c=%0d got=%b exp=%b", c, obsVec, predict());
            end
            if (c == 5 || c == 6) begin
                tests++;
                if (tgtDoneStatus !== ((c == 6) ? 4'b0001 : 4'b0000)) begin
                    fails++; $display("FAIL ignored_status c=%0d got=%b", c, tgtDoneStatus);
                end
            end
            if (c == 7 || c == 8) begin
                tests++;
                if (flushComplete !== (c == 8)) begin
                    fails++; $display("FAIL ignored_complete c=%0d got=%b", c, flushComplete);
                end
            end
            if (c == 10) begin
                tests++;
                if (tgtDoneStatus !== 4'b0101) begin
                    fails++; $display("FAIL ignored_hold got=%b exp=0101", tgtDoneStatus);
                end
            end
            tick();
        end
    endtask

    task automatic test_timeout(input bit lateDone);
        for (int c = 0; c <= 19; c++) begin
            setIn(1'b0, c == 0 || c == 18, 4'b0011, 4'b1111,
                  c == 3 ? 4'b0001 : ((c == 16 && lateDone) ? 4'b0010 : 4'b0000));
            tests++;
            if (obsVec !== predict()) begin
                fails++; $display("FAIL timeout%0d c=%0d got=%b exp=%b", lateDone, c, obsVec, predict());
            end
            if (c == 16) begin
                tests++;
                if ({busy, flushComplete} !== 2'b10) begin
                    fails++; $display("FAIL timeout_busy%0d got=%b exp=10", lateDone, {busy, flushComplete});
                end
            end
            if (c == 17) begin
                tests++;
                if ({flushComplete, flushTimeout} !== {1'b1, ~lateDone}) begin
                    fails++; $display("FAIL timeout_flag%0d got=%b exp=%b", lateDone,
                                      {flushComplete, flushTimeout}, {1'b1, ~lateDone});
                end
            end
            tick();
        end
    endtask

    task automatic test_zero_mask();
        for (int c = 0; c <= 3; c++) begin
            setIn(1'b0, c == 0 || c == 2, 4'b0000, 4'b1111, 4'b0000);
            tests++;
            if (obsVec !== predict()) begin
                fails++; $display("FAIL zero c=%0d got=%b exp=%b", c, obsVec, predict());
            end
            if (c == 1) begin
                tests++;
                if ({flushComplete, flushTimeout, busy, tgtFlushReq} !== 7'b1000000) begin
                    fails++; $display("FAIL zero_wait got=%b exp=1000000",
                                      {flushComplete, flushTimeout, busy, tgtFlushReq});
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_abandon();
        logic [NT-1:0] dn;
        for (int c = 0; c <= 14; c++) begin
            case (c)
                3:       dn = 4'b0001;
                6, 7:    dn = 4'b0010;
                11:      dn = 4'b0010;
                default: dn = 4'b0000;
            endcase
            setIn(c == 5, c == 0 || c == 8 || c == 13, c < 8 ? 4'b0011 : 4'b0010, 4'b1111, dn);
            tests++;
            if (obsVec !== predict()) begin
                fails++; $display("FAIL abandon c=%0d got=%b exp=%b", c, obsVec, predict());
            end
            if (c == 6 || c == 7) begin
                tests++;
                if (obsVec !== '0) begin
                    fails++; $display("FAIL abandon_zero c=%0d got=%b exp=0", c, obsVec);
                end
            end
            if (c == 12) begin
                tests++;
                if ({flushComplete, tgtDoneStatus} !== 5'b10010) begin
                    fails++; $display("FAIL abandon_restart got=%b exp=10010", {flushComplete, tgtDoneStatus});
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [NT-1:0] dn;
        for (int c = 0; c < 800; c++) begin
            dn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            setIn($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
                  4'($urandom), 4'($urandom), dn);
            tests++;
            if (obsVec !== predict()) begin
                fails++; $display("FAIL random c=%0d got=%b exp=%b", c, obsVec, predict());
            end
            tick();
        end
        setIn(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_staggered();
        test_ignored_done();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_zero_mask();
        test_reset_abandon();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_cache_flush_manager.md
MULTI_CACHE_FLUSH_MANAGER -- requirements
Module: multi_cache_flush_manager

Interface
REQ-001 The block SHALL have parameter NUM_TARGETS, default 2, giving the number of flushable caches (range 1..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the flush watchdog limit; value 0 disables the watchdog.
REQ-003 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-004 Port clk  in  1  clock.
REQ-005 Port rst  in  1  synchronous active-high reset.
REQ-006 Port flushReq  in  1  request from the replay/exec side; starts a flush in FREE and releases the block in WAITING.
REQ-007 Port flushMask  in  NUM_TARGETS  targets to flush, sampled only when a flush is accepted.
REQ-008 Port flushComplete  out  1  flush finished; held high throughout WAITING.
REQ-009 Port flushTimeout  out  1  the finished flush ended by watchdog; valid only while flushComplete is high.
REQ-010 Port busy  out  1  high in SEND_REQUEST and PROCESSING.
REQ-011 Port tgtFlushReq  out  NUM_TARGETS  one-cycle flush request pulse per target.
REQ-012 Port tgtFlushReqAck  in  NUM_TARGETS  target i can accept a request this cycle.
REQ-013 Port tgtFlushDone  in  NUM_TARGETS  one-cycle completion pulse from target i.
REQ-014 Port tgtDoneStatus  out  NUM_TARGETS  registered per-target done flags for debug and performance counters.

Function
REQ-015 The phase register SHALL use states FREE, SEND_REQUEST, PROCESSING and WAITING, and all outputs SHALL be decoded from registered state plus the current inputs.
REQ-016 In FREE with flushReq=1 and flushMask!=0, the block SHALL latch the mask, clear the issued and done flags, clear the watchdog, and enter SEND_REQUEST next cycle.
REQ-017 In FREE with flushReq=1 and flushMask=0, the block SHALL enter WAITING next cycle with flushTimeout=0.
REQ-018 In SEND_REQUEST, tgtFlushReq[i] SHALL equal mask[i] & ~issued[i] & tgtFlushReqAck[i], and issued[i] SHALL set on that cycle.
REQ-019 Targets SHALL be issued independently; the block SHALL NOT require simultaneous acks.
REQ-020 Each target SHALL receive exactly one request per flush.
REQ-021 The block SHALL leave SEND_REQUEST for PROCESSING on the cycle in which every masked target is issued, counting requests issued that cycle.
REQ-022 In SEND_REQUEST or PROCESSING, tgtFlushDone[i] SHALL set done[i] only if mask[i] and issued[i] are already registered.
REQ-023 A done pulse on an unmasked target, on a not-yet-issued target, or outside SEND_REQUEST/PROCESSING SHALL be ignored.
REQ-024 In PROCESSING, the block SHALL enter WAITING next cycle once (done | qualifying tgtFlushDone) covers the mask, so a same-cycle final done pulse counts.
REQ-025 The watchdog SHALL count cycles spent in SEND_REQUEST and PROCESSING, saturating at TIMEOUT_CYCLES-1.
REQ-026 When the watchdog count equals TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES!=0, the block SHALL enter WAITING and set the timeout flag.
REQ-027 If completion and timeout occur in the same cycle, completion SHALL win and the timeout flag SHALL stay 0.
REQ-028 In WAITING, flushComplete SHALL be 1 and flushTimeout SHALL equal the timeout flag.
REQ-029 In WAITING, flushReq=1 SHALL return the block to FREE next cycle; flushReq in the same cycle as that return SHALL NOT start a new flush.
REQ-030 Any unencoded phase value SHALL return the block to FREE next cycle with all outputs low.
REQ-031 tgtDoneStatus SHALL present the done flags, which hold their value through WAITING and clear on the next accepted flush.

Reset
REQ-032 On a clock edge with rst=1, the phase SHALL go to FREE, and the mask, issued flags, done flags, timeout flag and watchdog SHALL clear.
REQ-033 Reset SHALL force flushComplete, flushTimeout, busy, tgtFlushReq and tgtDoneStatus to 0 from that edge.
REQ-034 Reset during SEND_REQUEST or PROCESSING SHALL abandon the flush, and later tgtFlushDone pulses SHALL be ignored.

Structure
REQ-035 The phase enum and the default NUM_TARGETS and TIMEOUT_CYCLES values SHALL reside in CacheSystemTypes.
REQ-036 Per-target issued/done tracking SHALL be a sub-module, cache_flush_target_tracker, instantiated NUM_TARGETS times by generate.
REQ-037 The watchdog width SHALL be $clog2(TIMEOUT_CYCLES+1), with a minimum of 1 bit.

Verification
REQ-038 NUM_TARGETS=2, mask=11, both acks high: expect both tgtFlushReq pulses in cycle 1, dones at cycles 5 and 9, flushComplete=1 from cycle 10; a flushReq at cycle 12 returns the block to FREE at cycle 13.
REQ-039 Mask=11, ack0 high at cycle 1, ack1 high only at cycle 4: expect tgtFlushReq=01 at cycle 1 and 10 at cycle 4, no repeat requests, and PROCESSING from cycle 5.
REQ-040 NUM_TARGETS=4, mask=0101, done pulses on targets 1 and 3 plus an early done on 0 before issue: expect all three ignored, and completion only after dones on targets 0 and 2.
REQ-041 TIMEOUT_CYCLES=16, target 1 never sends done: expect WAITING with flushTimeout=1 after 16 busy cycles; a done arriving in the cycle of the 16th count gives flushTimeout=0.
REQ-042 Mask=00: expect WAITING one cycle after the request, with no tgtFlushReq pulse.
REQ-043 rst asserted in PROCESSING with one done outstanding: expect all outputs 0 next cycle, the late done ignored, and a new flush accepted normally.
